// File: rtl/risc_v_pkg.sv
// risc_v_pkg: shared RV32 constants and the jump-redirect state encoding.
package risc_v_pkg;
  localparam logic [6:0]  JAL_OPCODE  = 7'b1101111;
  localparam logic [6:0]  JALR_OPCODE = 7'b1100111;
  localparam logic [31:0] NOP_INSTR   = 32'h00000013;
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_RS1 = 2'd1;
  localparam logic [1:0] ST_REDIRECT = 2'd2;
  localparam logic [1:0] ST_DRAIN    = 2'd3;
  typedef enum logic [1:0] {
    S_IDLE     = ST_IDLE,
    S_WAIT_RS1 = ST_WAIT_RS1,
    S_REDIRECT = ST_REDIRECT,
    S_DRAIN    = ST_DRAIN
  } rd_state_e;
endpackage

// File: rtl/jump_redirect_unit.sv
// jump_redirect_unit: redirects the PC on decode jumps / execute branches and flushes wrong-path fetches.
module jump_redirect_unit
  import risc_v_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jump_req,
  input  logic                  jump_is_jalr,
  input  logic [DATA_WIDTH-1:0] jump_target,
  input  logic                  rs1_ready,
  input  logic                  stall,
  input  logic                  ex_branch_taken,
  input  logic [DATA_WIDTH-1:0] ex_branch_target,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_target,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  busy
);
  rd_state_e state_q, state_d;
  logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic br_q, br_d;
  logic [DATA_WIDTH-1:0] jalr_tgt;
  assign jalr_tgt = {jump_target[DATA_WIDTH-1:1], 1'b0};
  always_comb begin
    state_d = state_q;
    tgt_d = tgt_q;
    cnt_d = cnt_q;
    br_d = 1'b0;
    // an execute branch overrides everything, discarding any pending decode jump
    if (ex_branch_taken) begin
      state_d = S_REDIRECT;
      tgt_d = ex_branch_target;
      br_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: if (jump_req && !stall) begin
          state_d = (jump_is_jalr && !rs1_ready) ? S_WAIT_RS1 : S_REDIRECT;
          tgt_d = jump_is_jalr ? jalr_tgt : jump_target;
        end
        S_WAIT_RS1: if (rs1_ready) begin
          state_d = S_REDIRECT;
          tgt_d = jalr_tgt;
        end
        S_REDIRECT: begin
          cnt_d = CNT_W'(FLUSH_CYCLES - 1);
          state_d = (cnt_d == '0) ? S_IDLE : S_DRAIN;
        end
        S_DRAIN: begin
          cnt_d = cnt_q - 1'b1;
          state_d = (cnt_d == '0) ? S_IDLE : S_DRAIN;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tgt_q <= '0;
      cnt_q <= '0;
      br_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tgt_q <= tgt_d;
      cnt_q <= cnt_d;
      br_q <= br_d;
    end
  end
  assign redirect_valid = state_q == S_REDIRECT;
  assign redirect_target = redirect_valid ? tgt_q : '0;
  assign if_id_flush = redirect_valid || state_q == S_DRAIN;
  assign id_ex_flush = redirect_valid && br_q;
  assign busy = state_q != S_IDLE;
endmodule

// File: tb/tb_jump_redirect_unit.sv
// tb_jump_redirect_unit: directed scoreboard bench for FLUSH_CYCLES=1 and FLUSH_CYCLES=3 instances.
module tb_jump_redirect_unit;
  logic clk = 1'b0;
  logic rst, jr, jl, r1, stl, br;
  logic [31:0] jt, bt;
  logic rv1, iff1, ief1, busy1, rv3, iff3, ief3, busy3;
  logic [31:0] rt1, rt3;
  logic [35:0] o1, o3;
  int checks = 0;
  int errors = 0;
  typedef struct {
    int sel;
    logic [35:0] exp;
    string nm;
  } ent_t;
  ent_t q[$];
  always #5 clk = ~clk;
  jump_redirect_unit #(.DATA_WIDTH(32), .FLUSH_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst(rst), .jump_req(jr), .jump_is_jalr(jl), .jump_target(jt),
    .rs1_ready(r1), .stall(stl), .ex_branch_taken(br), .ex_branch_target(bt),
    .redirect_valid(rv1), .redirect_target(rt1), .if_id_flush(iff1),
    .id_ex_flush(ief1), .busy(busy1)
  );
  jump_redirect_unit #(.DATA_WIDTH(32), .FLUSH_CYCLES(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst(rst), .jump_req(jr), .jump_is_jalr(jl), .jump_target(jt),
    .rs1_ready(r1), .stall(stl), .ex_branch_taken(br), .ex_branch_target(bt),
    .redirect_valid(rv3), .redirect_target(rt3), .if_id_flush(iff3),
    .id_ex_flush(ief3), .busy(busy3)
  );
  assign o1 = {rv1, rt1, iff1, ief1, busy1};
  assign o3 = {rv3, rt3, iff3, ief3, busy3};
  function automatic logic [35:0] e(logic v, logic [31:0] t, logic f, logic x, logic b);
    return {v, t, f, x, b};
  endfunction
  task automatic drv(input logic j, input logic l, input logic [31:0] t, input logic r,
                     input logic s, input logic b, input logic [31:0] btg);
    jr = j; jl = l; jt = t; r1 = r; stl = s; br = b; bt = btg;
  endtask
  task automatic cyc(input int sel, input logic [35:0] exp, input string nm);
    ent_t en;
    en.sel = sel; en.exp = exp; en.nm = nm;
    q.push_back(en);
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input logic c, input string nm);
    checks++;
    if (c !== 1'b1) begin
      errors++;
      $display("FAIL %s: direct check o1=%h o3=%h", nm, o1, o3);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() != 0) begin
      ent_t en;
      logic [35:0] act;
      en = q.pop_front();
      act = (en.sel == 1) ? o1 : o3;
      checks++;
      if (act !== en.exp) begin
        errors++;
        $display("FAIL %s (F=%0d): got {rv,tgt,iff,ief,busy}=%h want %h", en.nm, en.sel, act, en.exp);
      end
    end
  end
  initial begin
    rst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(1, e(0, 0, 0, 0, 0), "reset1");
    cyc(3, e(0, 0, 0, 0, 0), "reset3");
    chk(o1 === 36'h0 && o3 === 36'h0, "reset_direct");
    rst = 1'b0;
    drv(1, 0, 32'h100, 0, 0, 0, 0);
    cyc(1, e(1, 32'h100, 1, 0, 1), "jal_redirect");
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(1, e(0, 0, 0, 0, 0), "jal_done");
    cyc(1, e(0, 0, 0, 0, 0), "jal_idle");
    drv(1, 1, 32'h205, 0, 0, 0, 0);
    cyc(1, e(0, 0, 0, 0, 1), "jalr_wait1");
    cyc(1, e(0, 0, 0, 0, 1), "jalr_wait2");
    chk(busy1 === 1'b1 && rv1 === 1'b0 && iff1 === 1'b0, "jalr_wait_direct");
    drv(1, 1, 32'h205, 1, 0, 0, 0);
    cyc(1, e(1, 32'h204, 1, 0, 1), "jalr_redirect");
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(1, e(0, 0, 0, 0, 0), "jalr_done");
    drv(1, 0, 32'h100, 0, 1, 0, 0);
    cyc(1, e(0, 0, 0, 0, 0), "stall1");
    cyc(1, e(0, 0, 0, 0, 0), "stall2");
    cyc(1, e(0, 0, 0, 0, 0), "stall3");
    drv(1, 0, 32'h100, 0, 0, 0, 0);
    cyc(1, e(1, 32'h100, 1, 0, 1), "stall_release");
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(1, e(0, 0, 0, 0, 0), "stall_done");
    drv(1, 0, 32'h100, 0, 0, 1, 32'h300);
    cyc(1, e(1, 32'h300, 1, 1, 1), "prio_branch");
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(1, e(0, 0, 0, 0, 0), "prio_after1");
    cyc(1, e(0, 0, 0, 0, 0), "prio_after2");
    drv(1, 1, 32'h777, 0, 0, 0, 0);
    cyc(1, e(0, 0, 0, 0, 1), "wait_pre");
    drv(1, 1, 32'h777, 1, 0, 1, 32'h301);
    cyc(1, e(1, 32'h301, 1, 1, 1), "wait_branch");
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(1, e(0, 0, 0, 0, 0), "wait_branch_done");
    rst = 1'b1;
    cyc(3, e(0, 0, 0, 0, 0), "reset3b");
    rst = 1'b0;
    drv(1, 0, 32'h40, 0, 0, 0, 0);
    cyc(3, e(1, 32'h40, 1, 0, 1), "f3_redirect");
    drv(1, 0, 32'h80, 0, 0, 0, 0);
    cyc(3, e(0, 0, 1, 0, 1), "f3_drain1");
    cyc(3, e(0, 0, 1, 0, 1), "f3_drain2");
    cyc(3, e(0, 0, 0, 0, 0), "f3_idle");
    cyc(3, e(1, 32'h80, 1, 0, 1), "f3_back2back");
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(3, e(0, 0, 1, 0, 1), "f3_drain_pre_rst");
    rst = 1'b1;
    cyc(3, e(0, 0, 0, 0, 0), "f3_mid_reset");
    rst = 1'b0;
    cyc(3, e(0, 0, 0, 0, 0), "f3_post_reset1");
    cyc(3, e(0, 0, 0, 0, 0), "f3_post_reset2");
    drv(1, 0, 32'h40, 0, 0, 0, 0);
    cyc(3, e(1, 32'h40, 1, 0, 1), "f3b_redirect");
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(3, e(0, 0, 1, 0, 1), "f3b_drain");
    drv(0, 0, 0, 0, 0, 1, 32'h501);
    cyc(3, e(1, 32'h501, 1, 1, 1), "f3b_branch");
    drv(0, 0, 0, 0, 0, 0, 0);
    cyc(3, e(0, 0, 1, 0, 1), "f3b_drain1");
    cyc(3, e(0, 0, 1, 0, 1), "f3b_drain2");
    cyc(3, e(0, 0, 0, 0, 0), "f3b_idle");
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
